// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, registered flush/redirect sequencing,
// and stall statistics (saturating cycle count plus consecutive-stall watchdog).
module pipe_ctrl #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        stallreq_from_ex,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  input  logic        stat_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        stall_timeout
);
  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0]  CNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO      = 16'(STALL_TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic [15:0] consec;
  logic        hit;

  // Redirects outrank stalls: nothing is held while the pipe is being cleared.
  always_comb begin
    stall = 6'b000000;
    if (rst && state == RUN && !flush_req) begin
      if (stallreq_from_ex)      stall = 6'b001111;
      else if (stallreq_from_id) stall = 6'b000111;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = new_pc;
    if (flush_req) begin
      state_nxt = FLUSH;
      cnt_nxt   = CNT_INIT;
      pc_nxt    = flush_pc;
    end else if (state == FLUSH) begin
      if (cnt == 4'd0) state_nxt = RUN;
      else             cnt_nxt   = cnt - 4'd1;
    end
  end

  assign flush = (state == FLUSH);
  assign hit   = stall[0] && (consec == TMO - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= RUN;
      cnt           <= 4'd0;
      new_pc        <= 32'd0;
      stall_cycles  <= 32'd0;
      consec        <= 16'd0;
      stall_timeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      new_pc <= pc_nxt;
      if (stat_clr)                                stall_cycles <= 32'd0;
      else if (stall[0] && stall_cycles != '1)     stall_cycles <= stall_cycles + 32'd1;
      if (!stall[0])                               consec <= 16'd0;
      else if (consec != TMO)                      consec <= consec + 16'd1;
      // Clear wins over a same-cycle timeout hit.
      if (stat_clr)                                stall_timeout <= 1'b0;
      else if (hit)                                stall_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: table of per-cycle vectors on a FLUSH_CYCLES=1
// instance, plus hand sequences for multi-cycle flush on a FLUSH_CYCLES=3 instance.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst, id, ex, fr, clr;
  logic [31:0] fpc;
  logic [5:0]  st0, st1;
  logic        fl0, fl1, to0, to1;
  logic [31:0] pc0, pc1, cyc0, cyc1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .STALL_TIMEOUT(4)) u0 (
    .clk(clk), .rst(rst), .stallreq_from_id(id), .stallreq_from_ex(ex),
    .flush_req(fr), .flush_pc(fpc), .stat_clr(clr), .stall(st0), .flush(fl0),
    .new_pc(pc0), .stall_cycles(cyc0), .stall_timeout(to0));

  pipe_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) u1 (
    .clk(clk), .rst(rst), .stallreq_from_id(id), .stallreq_from_ex(ex),
    .flush_req(fr), .flush_pc(fpc), .stat_clr(clr), .stall(st1), .flush(fl1),
    .new_pc(pc1), .stall_cycles(cyc1), .stall_timeout(to1));

  typedef struct {
    logic rst, id, ex, fr;
    logic [31:0] fpc;
    logic clr;
    logic [5:0] st;
    logic fl;
    logic [31:0] pc, cyc;
    logic to;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic r, i, e, f, input logic [31:0] p, input logic c,
                     input logic [5:0] s, input logic l, input logic [31:0] np,
                     input logic [31:0] cy, input logic t);
    vec_t v;
    v.rst = r; v.id = i; v.ex = e; v.fr = f; v.fpc = p; v.clr = c;
    v.st = s; v.fl = l; v.pc = np; v.cyc = cy; v.to = t;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r, i, e, f, input logic [31:0] p, input logic c);
    rst = r; id = i; ex = e; fr = f; fpc = p; clr = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // rst id ex fr fpc clr | stall flush new_pc cycles timeout
    add(0,1,1,1,32'h55 ,1, 6'h00,0,32'h0  ,0 ,0); // reset, everything high
    add(0,1,1,1,32'h55 ,1, 6'h00,0,32'h0  ,0 ,0);
    add(1,1,0,0,32'h0  ,0, 6'h07,0,32'h0  ,0 ,0); // ID stall x3
    add(1,1,0,0,32'h0  ,0, 6'h07,0,32'h0  ,1 ,0);
    add(1,1,0,0,32'h0  ,0, 6'h07,0,32'h0  ,2 ,0);
    add(1,0,0,0,32'h0  ,0, 6'h00,0,32'h0  ,3 ,0);
    add(1,1,1,0,32'h0  ,0, 6'h0F,0,32'h0  ,3 ,0); // both -> EX wins
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h0  ,4 ,0);
    add(1,0,1,1,32'h120,0, 6'h00,0,32'h0  ,5 ,0); // flush beats EX stall
    add(1,0,1,0,32'h0  ,0, 6'h00,1,32'h120,5 ,0); // in FLUSH: stall ignored
    add(1,0,0,0,32'h0  ,0, 6'h00,0,32'h120,5 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,5 ,0); // watchdog: 3 on
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,6 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,7 ,0);
    add(1,0,0,0,32'h0  ,0, 6'h00,0,32'h120,8 ,0); // 1 off
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,8 ,0); // 4 on
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,9 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,10,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,11,0);
    add(1,0,0,0,32'h0  ,1, 6'h00,0,32'h120,12,1); // timeout set; stat_clr
    add(1,0,0,0,32'h0  ,0, 6'h00,0,32'h120,0 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,0 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,1 ,0);
    add(1,0,1,0,32'h0  ,0, 6'h0F,0,32'h120,2 ,0);
    add(1,0,1,0,32'h0  ,1, 6'h0F,0,32'h120,3 ,0); // clr on the hit edge
    add(1,0,0,0,32'h0  ,0, 6'h00,0,32'h120,0 ,0);

    drive(0,1,1,1,32'h55,1);
    tick();
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].id, tv[k].ex, tv[k].fr, tv[k].fpc, tv[k].clr);
      #1;
      chk($sformatf("v%0d stall", k),  {26'd0, st0}, {26'd0, tv[k].st});
      chk($sformatf("v%0d flush", k),  {31'd0, fl0}, {31'd0, tv[k].fl});
      chk($sformatf("v%0d new_pc", k), pc0, tv[k].pc);
      chk($sformatf("v%0d cycles", k), cyc0, tv[k].cyc);
      chk($sformatf("v%0d timeout", k), {31'd0, to0}, {31'd0, tv[k].to});
      tick();
    end

    // Back-to-back flush, FLUSH_CYCLES=3
    drive(0,0,0,0,32'h0,0); tick(); tick();
    drive(1,0,0,1,32'h100,0); #1;
    chk("b2b stall", {26'd0, st1}, 32'd0);
    tick();                                   // edge N
    drive(1,0,0,0,32'h0,0); #1;
    chk("b2b N+1 flush", {31'd0, fl1}, 32'd1);
    chk("b2b N+1 pc", pc1, 32'h100);
    tick();                                   // edge N+1
    chk("b2b N+2 flush", {31'd0, fl1}, 32'd1);
    drive(1,0,0,1,32'h200,0);
    tick();                                   // edge N+2
    drive(1,0,0,0,32'h0,0); #1;
    chk("b2b N+3 flush", {31'd0, fl1}, 32'd1);
    chk("b2b N+3 pc", pc1, 32'h200);
    tick();
    chk("b2b N+4 flush", {31'd0, fl1}, 32'd1);
    tick();
    chk("b2b N+5 flush", {31'd0, fl1}, 32'd1);
    tick();
    chk("b2b N+6 flush", {31'd0, fl1}, 32'd0);
    chk("b2b N+6 pc", pc1, 32'h200);

    // Reset in cycle 2 of a 3-cycle flush, then a normal flush
    drive(1,0,0,1,32'h300,0); tick();
    drive(1,0,1,0,32'h0,0); #1;
    chk("rmf c1 flush", {31'd0, fl1}, 32'd1);
    chk("rmf c1 stall", {26'd0, st1}, 32'd0);
    tick();
    drive(0,0,1,0,32'h0,0); #1;
    chk("rmf rst stall", {26'd0, st1}, 32'd0);
    tick();
    drive(1,0,0,0,32'h0,0); #1;
    chk("rmf after flush", {31'd0, fl1}, 32'd0);
    chk("rmf after pc", pc1, 32'd0);
    drive(1,0,0,1,32'h400,0); tick();
    drive(1,0,0,0,32'h0,0); #1;
    chk("rmf refl flush", {31'd0, fl1}, 32'd1);
    chk("rmf refl pc", pc1, 32'h400);
    tick(); tick(); tick();
    chk("rmf refl end", {31'd0, fl1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
